hs1_rt_bm_responder: RTL and testbench

- Peer-side responder for the HS1 handshake protocol. Its controller issues WantRtHS1 and WantBmHS1 and waits on the Rdy/Full/Done flags; this block generates those flags.
- Answers each Want with a two-phase ready handshake (Rdy1, then Rdy2) on the router (Rt) and bus-master (Bm) channels.
- Models input and output buffer occupancy, which drives FullIHS1, FullOHS1 and InDoneHS1.
- Sits opposite the s953 control FSM in the same handshake loop. It is the drop-in stimulus/peer for that controller.

---
 rtl/hs1_pkg.sv | 15 +
 rtl/hs1_rdy_fsm.sv | 114 +++++++++++
 rtl/hs1_rt_bm_responder.sv | 121 ++++++++++++
 tb/tb_hs1_rt_bm_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hs1_pkg.sv
// Shared types and widths for the HS1 Rt/Bm handshake responder.
package hs1_pkg;

  localparam int CNT_W = 4;
  localparam int TMO_W = 8;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    WAIT1 = 5'b00010,
    RDY1  = 5'b00100,
    RDY2  = 5'b01000,
    DONE  = 5'b10000
  } hs_state_t;

endpackage

// File: rtl/hs1_rdy_fsm.sv
// One HS1 channel: Want -> Rdy1 -> Rdy2 -> completion, with programmable delays.
// Optional RDY2 watchdog when HS1_TIMEOUT_EN is defined.
module hs1_rdy_fsm
  import hs1_pkg::*;
#(
  parameter int RDY1_DLY = 1,
  parameter int RDY2_DLY = 2
`ifdef HS1_TIMEOUT_EN
  ,
  parameter int TMO_CYC  = 64
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic want,
  input  logic gate_ok,
  output logic rdy1,
  output logic rdy2,
  output logic cmpl,
  output logic tmo
);

  hs_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef HS1_TIMEOUT_EN
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             tmo_q, tmo_d;
`endif

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef HS1_TIMEOUT_EN
    wd_d    = '0;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (want && gate_ok) begin
          state_d = WAIT1;
          cnt_d   = CNT_W'(RDY1_DLY);
        end
      end
      WAIT1: begin
        if (!want) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RDY1;
          cnt_d   = CNT_W'(RDY2_DLY);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RDY1: begin
        if (!want) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RDY2;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RDY2: begin
        if (!want) begin
          state_d = DONE;
        end
`ifdef HS1_TIMEOUT_EN
        // Controller stuck with Want high: abandon the handshake, no completion.
        else if (wd_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HS1_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end
  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

  assign rdy1 = (state_q == RDY1) || (state_q == RDY2);
  assign rdy2 = (state_q == RDY2);
  assign cmpl = (state_q == DONE);

endmodule

// File: rtl/hs1_rt_bm_responder.sv
// HS1 peer responder: Rt and Bm handshake channels plus buffer occupancy flags.
// Define HS1_TIMEOUT_EN to add the per-channel RDY2 watchdog driving HsErr.
module hs1_rt_bm_responder
  import hs1_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RDY1_DLY = 1,
  parameter int RDY2_DLY = 2,
  parameter int TMO_CYC  = 64
) (
  input  logic CK,
  input  logic RN,
  input  logic WantRtHS1,
  input  logic WantBmHS1,
  input  logic PushI,
  output logic Rdy1RtHS1,
  output logic Rdy2RtHS1,
  output logic Rdy1BmHS1,
  output logic Rdy2BmHS1,
  output logic FullIHS1,
  output logic FullOHS1,
  output logic InDoneHS1,
  output logic HsErr
);

  if (DEPTH < 1 || DEPTH > 15 || RDY1_DLY < 0 || RDY1_DLY > 15 ||
      RDY2_DLY < 0 || RDY2_DLY > 15 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_cfg
    $error("hs1_rt_bm_responder: parameter out of range");
  end

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             in_done_q, in_done_d;
  logic             full_i_q, full_o_q;
  logic             rt_gate, bm_gate, push_ok;
  logic             rt_cmpl, bm_cmpl, rt_tmo, bm_tmo;

  assign rt_gate = (in_cnt_q != '0) && (out_cnt_q < DEPTH_C);
  assign bm_gate = (out_cnt_q != '0);
  assign push_ok = PushI && (in_cnt_q < DEPTH_C);

  hs1_rdy_fsm #(
    .RDY1_DLY(RDY1_DLY),
    .RDY2_DLY(RDY2_DLY)
`ifdef HS1_TIMEOUT_EN
    ,
    .TMO_CYC (TMO_CYC)
`endif
  ) u_rt (
    .clk    (CK),
    .rst_n  (RN),
    .want   (WantRtHS1),
    .gate_ok(rt_gate),
    .rdy1   (Rdy1RtHS1),
    .rdy2   (Rdy2RtHS1),
    .cmpl   (rt_cmpl),
    .tmo    (rt_tmo)
  );

  hs1_rdy_fsm #(
    .RDY1_DLY(RDY1_DLY),
    .RDY2_DLY(RDY2_DLY)
`ifdef HS1_TIMEOUT_EN
    ,
    .TMO_CYC (TMO_CYC)
`endif
  ) u_bm (
    .clk    (CK),
    .rst_n  (RN),
    .want   (WantBmHS1),
    .gate_ok(bm_gate),
    .rdy1   (Rdy1BmHS1),
    .rdy2   (Rdy2BmHS1),
    .cmpl   (bm_cmpl),
    .tmo    (bm_tmo)
  );

  // An Rt completion moves one entry from the input buffer to the output buffer.
  always_comb begin
    case ({push_ok, rt_cmpl})
      2'b10:   in_cnt_d = in_cnt_q + CNT_W'(1);
      2'b01:   in_cnt_d = in_cnt_q - CNT_W'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
    case ({rt_cmpl, bm_cmpl})
      2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    if (push_ok)
      in_done_d = 1'b0;
    else if (rt_cmpl && (in_cnt_q == CNT_W'(1)))
      in_done_d = 1'b1;
    else
      in_done_d = in_done_q;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_done_q <= 1'b0;
      full_i_q  <= 1'b0;
      full_o_q  <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_done_q <= in_done_d;
      full_i_q  <= (in_cnt_d == DEPTH_C);
      full_o_q  <= (out_cnt_d == DEPTH_C);
    end
  end

  assign FullIHS1  = full_i_q;
  assign FullOHS1  = full_o_q;
  assign InDoneHS1 = in_done_q;
  assign HsErr     = rt_tmo | bm_tmo;

endmodule

// File: tb/tb_hs1_rt_bm_responder.sv
// Randomized check of hs1_rt_bm_responder against a timing/occupancy model.
module tb_hs1_rt_bm_responder;

  localparam int DEPTH    = 4;
  localparam int RDY1_DLY = 1;
  localparam int RDY2_DLY = 2;
  localparam int TMO_CYC  = 64;

  logic CK = 1'b0;
  logic RN = 1'b0;
  logic WantRtHS1 = 1'b0, WantBmHS1 = 1'b0, PushI = 1'b0;
  logic Rdy1RtHS1, Rdy2RtHS1, Rdy1BmHS1, Rdy2BmHS1;
  logic FullIHS1, FullOHS1, InDoneHS1, HsErr;

  int n_checks = 0;
  int n_errors = 0;

  hs1_rt_bm_responder #(
    .DEPTH   (DEPTH),
    .RDY1_DLY(RDY1_DLY),
    .RDY2_DLY(RDY2_DLY),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .CK       (CK),
    .RN       (RN),
    .WantRtHS1(WantRtHS1),
    .WantBmHS1(WantBmHS1),
    .PushI    (PushI),
    .Rdy1RtHS1(Rdy1RtHS1),
    .Rdy2RtHS1(Rdy2RtHS1),
    .Rdy1BmHS1(Rdy1BmHS1),
    .Rdy2BmHS1(Rdy2BmHS1),
    .FullIHS1 (FullIHS1),
    .FullOHS1 (FullOHS1),
    .InDoneHS1(InDoneHS1),
    .HsErr    (HsErr)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {Rdy1RtHS1, Rdy2RtHS1, Rdy1BmHS1, Rdy2BmHS1, FullIHS1, FullOHS1, InDoneHS1, HsErr};
  endfunction

  // Model: per channel, "cycles since the Want was accepted" decides Rdy1/Rdy2.
  bit act[2];
  int age[2];
  bit fin[2];
  int m_in, m_out;
  bit m_done;

  function automatic bit m_rdy1(int c);
    return act[c] && (age[c] >= RDY1_DLY + 1);
  endfunction

  function automatic bit m_rdy2(int c);
    return act[c] && (age[c] >= RDY1_DLY + RDY2_DLY + 2);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      act[c] = 0; age[c] = 0; fin[c] = 0;
    end
    m_in = 0; m_out = 0; m_done = 0;
  endtask

  task automatic model_step(input bit w_rt, input bit w_bm, input bit push);
    bit w[2];
    bit gate[2];
    bit rt_c, bm_c, push_ok;
    w[0] = w_rt; w[1] = w_bm;
    gate[0] = (m_in > 0) && (m_out < DEPTH);
    gate[1] = (m_out > 0);
    rt_c = fin[0];
    bm_c = fin[1];
    push_ok = push && (m_in < DEPTH);
    for (int c = 0; c < 2; c++) begin
      if (fin[c]) begin
        fin[c] = 0;
      end else if (act[c]) begin
        if (!w[c]) begin
          fin[c] = m_rdy2(c);
          act[c] = 0;
        end else begin
          age[c]++;
        end
      end else if (w[c] && gate[c]) begin
        act[c] = 1;
        age[c] = 0;
      end
    end
    m_in  = m_in + int'(push_ok) - int'(rt_c);
    m_out = m_out + int'(rt_c) - int'(bm_c);
    if (push_ok) m_done = 0;
    else if (rt_c && m_in == 0) m_done = 1;
  endtask

  function automatic logic [7:0] model_outs();
    return {m_rdy1(0), m_rdy2(0), m_rdy1(1), m_rdy2(1),
            m_in == DEPTH, m_out == DEPTH, m_done, 1'b0};
  endfunction

  initial begin
    int wait_n;
    bit w_rt, w_bm, push;
    int hold_rt, hold_bm;
    int p_push[3] = '{60, 30, 15};
    int p_rt[3]   = '{40, 40, 20};
    int p_bm[3]   = '{5, 30, 60};

    // Reset and abort of a live handshake.
    #12;
    check("reset_outs", 32'(outs()), 32'h0);
    @(negedge CK) RN = 1'b1;
    PushI = 1'b1;
    @(negedge CK);
    @(negedge CK) PushI = 1'b0;
    WantRtHS1 = 1'b1;
    wait_n = 0;
    while (!Rdy1RtHS1 && wait_n < 20) begin
      @(negedge CK);
      wait_n++;
    end
    check("rt_rdy1_reached", 32'(Rdy1RtHS1), 32'h1);
    #2 RN = 1'b0;
    #1 check("async_reset_outs", 32'(outs()), 32'h0);
    WantRtHS1 = 1'b0;
    @(negedge CK) RN = 1'b1;
    check("post_reset_fulli", 32'(FullIHS1), 32'h0);
    // in_cnt must be 0 again: an Rt Want stays held off.
    WantRtHS1 = 1'b1;
    repeat (10) @(negedge CK);
    check("post_reset_gate_off", 32'({Rdy1RtHS1, Rdy2RtHS1}), 32'h0);
    WantRtHS1 = 1'b0;
    @(negedge CK);

    // Randomized phases with shifting traffic mix.
    model_reset();
    w_rt = 0; w_bm = 0; hold_rt = 0; hold_bm = 0;
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 1500; i++) begin
        @(negedge CK);
        check($sformatf("cyc_outs e%0d i%0d", e, i), 32'(outs()), 32'(model_outs()));
        if (!w_rt) begin
          if ($urandom_range(99) < p_rt[e]) begin w_rt = 1; hold_rt = 0; end
        end else begin
          hold_rt++;
          if (hold_rt > 40 || $urandom_range(99) < 8) w_rt = 0;
        end
        if (!w_bm) begin
          if ($urandom_range(99) < p_bm[e]) begin w_bm = 1; hold_bm = 0; end
        end else begin
          hold_bm++;
          if (hold_bm > 40 || $urandom_range(99) < 8) w_bm = 0;
        end
        push = ($urandom_range(99) < p_push[e]);
        WantRtHS1 = w_rt;
        WantBmHS1 = w_bm;
        PushI     = push;
        model_step(w_rt, w_bm, push);
      end
    end
    WantRtHS1 = 1'b0;
    WantBmHS1 = 1'b0;
    PushI     = 1'b0;

`ifdef HS1_TIMEOUT_EN
    // Watchdog: Want held in RDY2 for TMO_CYC cycles.
    @(negedge CK) RN = 1'b0;
    @(negedge CK) RN = 1'b1;
    PushI = 1'b1;
    @(negedge CK) PushI = 1'b0;
    WantRtHS1 = 1'b1;
    wait_n = 0;
    while (!Rdy2RtHS1 && wait_n < 30) begin
      @(negedge CK);
      wait_n++;
    end
    check("tmo_rdy2_reached", 32'(Rdy2RtHS1), 32'h1);
    wait_n = 0;
    while (!HsErr && wait_n < 100) begin
      @(negedge CK);
      wait_n++;
    end
    check("tmo_cycles", 32'(wait_n), 32'(TMO_CYC));
    check("tmo_rdy_off", 32'({Rdy1RtHS1, Rdy2RtHS1}), 32'h0);
    WantRtHS1 = 1'b0;
    @(negedge CK);
    check("tmo_pulse_width", 32'(HsErr), 32'h0);
    check("tmo_no_cmpl", 32'({InDoneHS1, FullOHS1}), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
